// File: rtl/seq_divider16_if.sv
// seq_divider16_if: start/done handshake and operand/result bundle for the
// sequential divider.
//   master : drives start, dividend, divisor; observes busy, done, results
//   slave  : the divider; consumes operands, drives busy, done, quotient,
//            remainder, div_by_zero
interface seq_divider16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider16.sv
// seq_divider16: iterative restoring radix-2 divider, one quotient bit per
// clock. 16 iterations per division, start/done handshake.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  seq_divider16_if.slave (start, dividend, divisor in;
//        busy, done, quotient, remainder, div_by_zero out)
//
// Build option: define SIGNED_DIV_EN for two's-complement operands
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Without it the divider is purely unsigned.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; results held
// CALC  | one restoring iteration per edge, busy high
// DONE  | done high for one cycle; may accept a new start
module seq_divider16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  seq_divider16_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  // The partial remainder is always below the divisor, so WIDTH bits hold
  // it; the extra bit only appears in the trial difference below.
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CNT_W-1:0] count;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_d;
  logic [WIDTH-1:0] zero_quot;

`ifdef SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;
`endif

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

  // One restoring step: shift the next dividend bit into the remainder and
  // keep the difference only if it did not go negative.
  always_comb begin
    shifted = {r_reg, q_reg[WIDTH-1]};
    trial   = shifted - {1'b0, d_reg};
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      r_next = shifted[WIDTH-1:0];
      q_next = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

`ifdef SIGNED_DIV_EN
  // Divide magnitudes, then fix signs on the result-writing edge.
  // 0x8000 has no positive counterpart but its unsigned magnitude is still
  // 0x8000, which makes 0x8000 / -1 come out as 0x8000 rem 0.
  always_comb begin
    load_a    = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    load_d    = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    q_final   = neg_q ? -q_next : q_next;
    r_final   = neg_r ? -r_next : r_next;
    zero_quot = bus.dividend[WIDTH-1] ? WIDTH'(1) : '1;
  end
`else
  always_comb begin
    load_a    = bus.dividend;
    load_d    = bus.divisor;
    q_final   = q_next;
    r_final   = r_next;
    zero_quot = '1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q_reg  <= '0;
      r_reg  <= '0;
      d_reg  <= '0;
      count  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
`ifdef SIGNED_DIV_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            if (bus.divisor == '0) begin
              // Divide by zero skips CALC entirely: results on the next cycle.
              state  <= DONE;
              done_r <= 1'b1;
              quot_r <= zero_quot;
              rem_r  <= bus.dividend;
              dbz_r  <= 1'b1;
            end else begin
              q_reg  <= load_a;
              r_reg  <= '0;
              d_reg  <= load_d;
              count  <= '0;
              busy_r <= 1'b1;
              dbz_r  <= 1'b0;
              state  <= CALC;
`ifdef SIGNED_DIV_EN
              neg_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              neg_r  <= bus.dividend[WIDTH-1];
`endif
            end
          end else begin
            state <= IDLE;
          end
        end

        CALC: begin
          q_reg <= q_next;
          r_reg <= r_next;
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            quot_r <= q_final;
            rem_r  <= r_final;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider16.sv
module tb_seq_divider16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_divider16_if #(.WIDTH(16)) dif ();

  seq_divider16 #(.WIDTH(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_q;
    logic [15:0] exp_r;
    logic        exp_z;
    int          exp_edge;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain language-level division on the operand values.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic z);
`ifdef SIGNED_DIV_EN
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = (sa < 0) ? 16'd1 : 16'hFFFF;
      r = a;
      z = 1'b1;
    end else begin
      q = 16'(sa / sb);
      r = 16'(sa % sb);
      z = 1'b0;
    end
`else
    if (b == 16'd0) begin
      q = 16'hFFFF;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
`endif
  endfunction

  // Called at a negedge. Returns the index k of the edge E_k (E0 = accepting
  // edge) after which done was first seen, and the number of busy cycles.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output int done_edge, output int busy_cnt, output logic timed_out);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(posedge clk);
    #1;
    dif.start    = 1'b0;
    dif.dividend = 16'($urandom);
    dif.divisor  = 16'($urandom);
    done_edge = -1;
    busy_cnt  = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.busy) busy_cnt++;
      if (dif.done) begin
        done_edge = i;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  int          de;
  int          bc;
  logic        to;
  int          done_seen;
  logic [15:0] mq;
  logic [15:0] mr;
  logic        mz;
  logic [15:0] ra;
  logic [15:0] rb;
  int          sel;

  initial begin
    vecs.push_back('{16'd100,   16'd7,      16'd14,    16'd2,    1'b0, 16});
    vecs.push_back('{16'hFFFF,  16'h0001,   16'hFFFF,  16'h0000, 1'b0, 16});
    vecs.push_back('{16'h0003,  16'h0005,   16'h0000,  16'h0003, 1'b0, 16});
    vecs.push_back('{16'hFFFF,  16'hFFFF,   16'h0001,  16'h0000, 1'b0, 16});
    vecs.push_back('{16'd1234,  16'd0,      16'hFFFF,  16'd1234, 1'b1, 0});
    vecs.push_back('{16'd10,    16'd3,      16'd3,     16'd1,    1'b0, 16});
`ifdef SIGNED_DIV_EN
    vecs.push_back('{16'hFFF9,  16'd2,      16'hFFFD,  16'hFFFF, 1'b0, 16});
    vecs.push_back('{16'd7,     16'hFFFE,   16'hFFFD,  16'h0001, 1'b0, 16});
    vecs.push_back('{16'h8000,  16'hFFFF,   16'h8000,  16'h0000, 1'b0, 16});
    vecs.push_back('{16'hFFFB,  16'd0,      16'h0001,  16'hFFFB, 1'b1, 0});
`endif

    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = 16'd0;
    dif.divisor  = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset busy",      {31'd0, dif.busy}, 32'd0);
    check("reset done",      {31'd0, dif.done}, 32'd0);
    check("reset quotient",  {16'd0, dif.quotient}, 32'd0);
    check("reset remainder", {16'd0, dif.remainder}, 32'd0);
    check("reset dbz",       {31'd0, dif.div_by_zero}, 32'd0);

    // Table vectors, each followed by an idle cycle to see done drop.
    foreach (vecs[k]) begin
      do_op(vecs[k].a, vecs[k].b, de, bc, to);
      check($sformatf("vec%0d timeout", k), {31'd0, to}, 32'd0);
      check($sformatf("vec%0d done edge", k), de, vecs[k].exp_edge);
      check($sformatf("vec%0d busy cycles", k), bc, (vecs[k].exp_z ? 0 : 16));
      check($sformatf("vec%0d quotient", k), {16'd0, dif.quotient}, {16'd0, vecs[k].exp_q});
      check($sformatf("vec%0d remainder", k), {16'd0, dif.remainder}, {16'd0, vecs[k].exp_r});
      check($sformatf("vec%0d dbz", k), {31'd0, dif.div_by_zero}, {31'd0, vecs[k].exp_z});
      @(negedge clk);
      check($sformatf("vec%0d done pulse", k), {31'd0, dif.done}, 32'd0);
      check($sformatf("vec%0d quotient held", k), {16'd0, dif.quotient}, {16'd0, vecs[k].exp_q});
    end

    // start during CALC with other operands must be ignored.
    dif.start = 1'b1; dif.dividend = 16'd200; dif.divisor = 16'd9;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (5) @(negedge clk);
    dif.start = 1'b1; dif.dividend = 16'd999; dif.divisor = 16'd3;
    @(posedge clk); #1;
    dif.start = 1'b0;
    de = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.done) begin
        de = 5 + i;
        break;
      end
    end
    check("ignore start done edge", de, 16);
    check("ignore start quotient",  {16'd0, dif.quotient}, 32'd22);
    check("ignore start remainder", {16'd0, dif.remainder}, 32'd2);
    @(negedge clk);

    // Back-to-back: start held during DONE is accepted at once.
    do_op(16'd100, 16'd7, de, bc, to);
    check("b2b first quotient", {16'd0, dif.quotient}, 32'd14);
    do_op(16'd50, 16'd6, de, bc, to);
    check("b2b timeout", {31'd0, to}, 32'd0);
    check("b2b done edge", de, 16);
    check("b2b quotient",  {16'd0, dif.quotient}, 32'd8);
    check("b2b remainder", {16'd0, dif.remainder}, 32'd2);
    @(negedge clk);

    // Reset in the middle of an operation.
    dif.start = 1'b1; dif.dividend = 16'd1000; dif.divisor = 16'd3;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy",      {31'd0, dif.busy}, 32'd0);
    check("midrst done",      {31'd0, dif.done}, 32'd0);
    check("midrst quotient",  {16'd0, dif.quotient}, 32'd0);
    check("midrst remainder", {16'd0, dif.remainder}, 32'd0);
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (dif.done) done_seen++;
    end
    check("midrst no done", done_seen, 0);

    // Random operands against the reference model, run back-to-back.
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 15));
      ra  = 16'($urandom);
      if (sel == 0)      rb = 16'd0;
      else if (sel < 5)  rb = 16'($urandom_range(1, 15));
      else               rb = 16'($urandom);
      model(ra, rb, mq, mr, mz);
      do_op(ra, rb, de, bc, to);
      if (to) begin
        check("random timeout", {31'd0, to}, 32'd0);
        break;
      end
      check("random quotient",  {16'd0, dif.quotient}, {16'd0, mq});
      check("random remainder", {16'd0, dif.remainder}, {16'd0, mr});
      check("random dbz",       {31'd0, dif.div_by_zero}, {31'd0, mz});
`ifndef SIGNED_DIV_EN
      if (rb != 16'd0) begin
        check("random identity", 32'(dif.quotient) * 32'(rb) + 32'(dif.remainder), 32'(ra));
        check("random rem<div",  {31'd0, (dif.remainder < rb)}, 32'd1);
      end
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
